// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM that feeds decode.
// Redirects override everything and flush any in-flight or held instruction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        fetch_misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        misalign_q, misalign_d;

    // State and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= 32'h0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state and datapath updates; redirect takes priority over all events
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            if_valid_d = 1'b0;
            case (state_q)
                // A request accepted this cycle is now stale
                S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
                // An arriving response closes the outstanding request
                S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        fetch_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if_instr_d = imem_resp_data;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (id_ready) begin
                        if_valid_d = 1'b0;
                        state_d    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                    if_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory and
// decode, queuing expected deliveries as responses are driven.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        fetch_misalign;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request at address a, stalling ready for 'stall' cycles
    task automatic issue(input logic [31:0] a, input int stall);
        imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", imem_req_addr, a);
            tick();
        end
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, a);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    endtask

    // Return data after 'delay' idle cycles; record the expected delivery
    task automatic respond(input logic [31:0] a, input logic [31:0] d,
                           input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("wait_if_valid", {31'b0, if_valid}, 32'd0);
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        sb_q.push_back({a, d});
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
    endtask

    // Check a held instruction for 'stall' cycles, optionally consume it
    task automatic hold_check(input int stall, input bit consume);
        logic [63:0] e;
        chk("sb_nonempty", sb_q.size(), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'h0;
        for (int i = 0; i <= stall; i++) begin
            chk("hold_if_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_if_instr", if_instr, e[31:0]);
            chk("hold_if_pc", if_pc, e[63:32]);
            chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
            if (i < stall) tick();
        end
        if (consume) begin
            id_ready = 1'b1;
            tick();
            id_ready = 1'b0;
            chk("after_take_if_valid", {31'b0, if_valid}, 32'd0);
            chk("after_take_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b0;
        @(negedge clk);
        tick();

        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

        rst = 1'b0;
        chk("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();

        // Basic fetch
        issue(32'h0, 0);
        respond(32'h0, 32'h0000_0013, 0);
        hold_check(0, 1'b1);
        chk("next_addr_4", imem_req_addr, 32'h4);

        // Memory backpressure
        issue(32'h4, 3);
        respond(32'h4, 32'h1111_2222, 0);
        hold_check(0, 1'b1);
        chk("next_addr_8", imem_req_addr, 32'h8);

        // Decode backpressure
        issue(32'h8, 0);
        respond(32'h8, 32'h3333_4444, 1);
        hold_check(4, 1'b1);
        chk("next_addr_c", imem_req_addr, 32'hC);

        // Redirect while waiting: response is drained
        issue(32'hC, 0);
        redirect(32'h0000_0100);
        chk("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("drain_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("drop_if_valid", {31'b0, if_valid}, 32'd0);
        chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("drop_req_addr", imem_req_addr, 32'h100);
        issue(32'h100, 0);
        respond(32'h100, 32'h5555_6666, 0);
        hold_check(0, 1'b1);

        // Misaligned redirect in REQ without handshake
        redirect(32'h0000_0102);
        chk("misalign_pulse", {31'b0, fetch_misalign}, 32'd1);
        chk("misalign_addr", imem_req_addr, 32'h100);
        tick();
        chk("misalign_clear", {31'b0, fetch_misalign}, 32'd0);
        chk("misalign_req", {31'b0, imem_req_valid}, 32'd1);

        // Redirect in HOLD with id_ready: instruction not delivered
        issue(32'h100, 0);
        respond(32'h100, 32'h7777_8888, 0);
        hold_check(0, 1'b0);
        id_ready = 1'b1;
        redirect(32'h0000_0200);
        id_ready = 1'b0;
        chk("hold_redir_if_valid", {31'b0, if_valid}, 32'd0);
        chk("hold_redir_addr", imem_req_addr, 32'h200);
        chk("hold_redir_misalign", {31'b0, fetch_misalign}, 32'd0);

        // Redirect coinciding with a handshake: accepted request is stale
        imem_req_ready = 1'b1;
        redirect(32'h0000_0300);
        imem_req_ready = 1'b0;
        chk("stale_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk("stale_addr", imem_req_addr, 32'h300);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        tick();
        imem_resp_valid = 1'b0;
        chk("stale_if_valid", {31'b0, if_valid}, 32'd0);
        chk("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);

        // Address wrap
        redirect(32'hFFFF_FFFC);
        issue(32'hFFFF_FFFC, 0);
        respond(32'hFFFF_FFFC, 32'h9999_AAAA, 0);
        hold_check(0, 1'b1);
        chk("wrap_addr", imem_req_addr, 32'h0);

        // Reset mid-transaction; late response ignored
        issue(32'h0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        tick();
        chk("late_resp_req", {31'b0, imem_req_valid}, 32'd1);
        chk("late_resp_if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        imem_resp_valid = 1'b0;
        chk("late_resp2_req", {31'b0, imem_req_valid}, 32'd1);
        chk("late_resp2_addr", imem_req_addr, 32'h0);
        chk("late_resp2_if_valid", {31'b0, if_valid}, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-004 redirect_valid  input  1  SHALL mean a taken jump/branch target is presented this cycle.
REQ-005 redirect_pc  input  32  SHALL be the new fetch address; it is valid when redirect_valid=1.
REQ-006 imem_req_valid  output  1  SHALL mean a fetch request is presented.
REQ-007 imem_req_ready  input  1  SHALL mean instruction memory accepts the request this cycle.
REQ-008 imem_req_addr  output  32  SHALL be the word-aligned fetch address.
REQ-009 imem_resp_valid  input  1  SHALL mean imem_resp_data holds the response to the oldest accepted request.
REQ-010 imem_resp_data  input  32  SHALL be the fetched instruction word.
REQ-011 if_valid  output  1  SHALL mean if_instr/if_pc hold an instruction for decode.
REQ-012 if_instr  output  32  SHALL be the instruction handed to decode.
REQ-013 if_pc  output  32  SHALL be the address of if_instr.
REQ-014 id_ready  input  1  SHALL mean decode consumes if_instr this cycle.
REQ-015 fetch_misalign  output  1  SHALL pulse for one cycle when redirect_pc[1:0]!=0.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD and DRAIN, with at most one request outstanding.
REQ-017 IDLE SHALL go to REQ unconditionally on the next clock.
REQ-018 imem_req_valid SHALL be 1 only in REQ; imem_req_addr SHALL equal pc_q.
REQ-019 In REQ, when imem_req_ready=1: go to WAIT, latch fetch_pc_q<=pc_q, and set pc_q<=pc_q+4 (mod 2^32, wrap 32'hFFFF_FFFC->0).
REQ-020 imem_req_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0, except when a redirect occurs.
REQ-021 In WAIT, when imem_resp_valid=1: capture if_instr<=imem_resp_data and if_pc<=fetch_pc_q, set if_valid<=1, and go to HOLD.
REQ-022 In HOLD, if_valid=1 and the if_instr/if_pc values SHALL stay stable until id_ready=1; then if_valid<=0 and go to REQ.
REQ-023 if_valid SHALL be 0 in every state except HOLD.
REQ-024 Redirect SHALL have priority over every other event and set pc_q<={redirect_pc[31:2],2'b00}.
REQ-025 A redirect SHALL clear if_valid on the next edge, including in HOLD with id_ready=1; that instruction SHALL NOT be considered delivered.
REQ-026 Redirect state transitions:
- redirect in WAIT without imem_resp_valid -> DRAIN;
- redirect in REQ with imem_req_ready=1 -> DRAIN; the accepted request is stale;
- redirect in WAIT with imem_resp_valid=1 -> response discarded, go to REQ;
- redirect in REQ without handshake, in HOLD, or in IDLE -> REQ.
REQ-027 DRAIN SHALL wait for imem_resp_valid, discard the data, and go to REQ without updating if_* outputs.
REQ-028 A redirect in DRAIN SHALL update pc_q and remain in DRAIN.
REQ-029 fetch_misalign SHALL be registered: 1 on the cycle after a redirect with nonzero redirect_pc[1:0], else 0.
REQ-030 imem_resp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-031 While rst=1 the block SHALL hold:
- state=IDLE, pc_q=RESET_PC, fetch_pc_q=0;
- if_valid=0, if_instr=0, if_pc=0;
- imem_req_valid=0, fetch_misalign=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response SHALL be ignored per REQ-030.

Verification
REQ-033 Release reset, imem_req_ready=1, response 1 cycle later with 32'h00000013, id_ready=1 -> first request addr 0, then if_valid=1 with if_instr=32'h00000013 and if_pc=0; the next request addr is 4.
REQ-034 Hold imem_req_ready=0 for 3 cycles -> imem_req_valid=1 with addr stable for all 3 cycles and no pc advance.
REQ-035 Hold id_ready=0 for 4 cycles in HOLD -> if_valid, if_instr and if_pc unchanged; no new request issued.
REQ-036 Redirect to 32'h0000_0100 while in WAIT, response arrives 2 cycles later -> response dropped, if_valid stays 0, next request addr is 32'h100.
REQ-037 Redirect to 32'h0000_0102 -> fetch_misalign pulses for 1 cycle and the next request addr is 32'h100.
REQ-038 With pc_q=32'hFFFF_FFFC, complete a fetch -> the next request addr is 32'h0000_0000.
